// File: rtl/adder_bist_driver.sv
// Self-test initiator for small adders: sweeps every {b,a} operand pair, waits a
// settle time, then compares the adder result against a behavioural a+b.
module adder_bist_driver #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   dut_a,
    output logic [WIDTH-1:0]   dut_b,
    input  logic [WIDTH-1:0]   dut_sum,
    input  logic               dut_cout,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic               first_fail_valid,
    output logic [2*WIDTH-1:0] first_fail_vec
);

    // state     | meaning
    // ST_IDLE   | waiting for start after reset
    // ST_DRIVE  | register operands of vector v onto dut_a/dut_b
    // ST_SETTLE | let the adder settle for SETTLE cycles
    // ST_CHECK  | sample and compare the adder result
    // ST_DONE   | sweep finished, results held until start or rst
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [2*WIDTH-1:0] V_LAST = '1;

    state_t             state;
    state_t             state_next;
    logic [2*WIDTH-1:0] v;
    logic [CNT_W-1:0]   cnt;
    logic               last_vec;
    logic               mismatch;

    assign last_vec = (v == V_LAST);
    // Compare against the operands the adder actually saw, not the counter.
    assign mismatch = {dut_cout, dut_sum} != ({1'b0, dut_a} + {1'b0, dut_b});

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) state_next = ST_DRIVE;
            end
            ST_DRIVE:  state_next = (SETTLE > 0) ? ST_SETTLE : ST_CHECK;
            ST_SETTLE: begin
                if (cnt == '0) state_next = ST_CHECK;
            end
            ST_CHECK:  state_next = last_vec ? ST_DONE : ST_DRIVE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_DRIVE) || (state == ST_SETTLE) || (state == ST_CHECK);
        done = (state == ST_DONE);
        pass = done && (err_count == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v                <= '0;
            cnt              <= '0;
            dut_a            <= '0;
            dut_b            <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        v                <= '0;
                        err_count        <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
                    end
                end
                ST_DRIVE: begin
                    dut_a <= v[WIDTH-1:0];
                    dut_b <= v[2*WIDTH-1:WIDTH];
                    cnt   <= CNT_LOAD;
                end
                ST_SETTLE: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (err_count != '1) err_count <= err_count + 1'b1;
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_vec   <= v;
                        end
                    end
                    if (!last_vec) v <= v + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_bist_driver.sv
// Bench for adder_bist_driver: three instances (SETTLE=1/ERR_W=8, ERR_W=4, SETTLE=0)
// each driving a behavioural adder with a selectable fault.
module tb_adder_bist_driver;

    typedef struct {
        int         cycles;
        logic [7:0] err;
        logic       ffv;
        logic [7:0] ffvec;
        logic       pass;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start_v = '0;
    logic [2:0] busy_v, done_v, pass_v, ffv_v;
    logic [3:0] a_v [3];
    logic [3:0] b_v [3];
    logic [3:0] sum_v [3];
    logic       cout_v [3];
    logic [7:0] err_v [3];
    logic [3:0] err1;
    logic [7:0] ffvec_v [3];
    int         mode_v [3] = '{0, 0, 0};

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // mode 0 ideal, 1 sum[0] stuck at 0, 2 carry-out stuck at 0, 3 inverted sum
    function automatic logic [4:0] fault_add(input int mode, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] r;
        r = {1'b0, a} + {1'b0, b};
        case (mode)
            1: r[0] = 1'b0;
            2: r[4] = 1'b0;
            3: r[3:0] = ~r[3:0];
            default: ;
        endcase
        return r;
    endfunction

    assign {cout_v[0], sum_v[0]} = fault_add(mode_v[0], a_v[0], b_v[0]);
    assign {cout_v[1], sum_v[1]} = fault_add(mode_v[1], a_v[1], b_v[1]);
    assign {cout_v[2], sum_v[2]} = fault_add(mode_v[2], a_v[2], b_v[2]);
    assign err_v[1] = {4'b0000, err1};

    adder_bist_driver #(.WIDTH(4), .SETTLE(1), .ERR_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start_v[0]),
        .dut_a(a_v[0]), .dut_b(b_v[0]), .dut_sum(sum_v[0]), .dut_cout(cout_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_v[0]),
        .first_fail_valid(ffv_v[0]), .first_fail_vec(ffvec_v[0])
    );

    adder_bist_driver #(.WIDTH(4), .SETTLE(1), .ERR_W(4)) u_dut_e4 (
        .clk(clk), .rst(rst), .start(start_v[1]),
        .dut_a(a_v[1]), .dut_b(b_v[1]), .dut_sum(sum_v[1]), .dut_cout(cout_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err1),
        .first_fail_valid(ffv_v[1]), .first_fail_vec(ffvec_v[1])
    );

    adder_bist_driver #(.WIDTH(4), .SETTLE(0), .ERR_W(8)) u_dut_s0 (
        .clk(clk), .rst(rst), .start(start_v[2]),
        .dut_a(a_v[2]), .dut_b(b_v[2]), .dut_sum(sum_v[2]), .dut_cout(cout_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err_v[2]),
        .first_fail_valid(ffv_v[2]), .first_fail_vec(ffvec_v[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input int i, input string tag);
        check({tag, " busy"}, 32'(busy_v[i]), 0);
        check({tag, " done"}, 32'(done_v[i]), 0);
        check({tag, " pass"}, 32'(pass_v[i]), 0);
        check({tag, " err_count"}, 32'(err_v[i]), 0);
        check({tag, " ff_valid"}, 32'(ffv_v[i]), 0);
        check({tag, " ff_vec"}, 32'(ffvec_v[i]), 0);
        check({tag, " dut_a"}, 32'(a_v[i]), 0);
        check({tag, " dut_b"}, 32'(b_v[i]), 0);
    endtask

    // Independent model of a whole sweep: count mismatches over all {b,a}.
    function automatic exp_t model_sweep(input int settle, input int errw, input int mode);
        exp_t e;
        int   errs;
        logic [7:0] v8;
        errs    = 0;
        e.ffv   = 1'b0;
        e.ffvec = '0;
        for (int v = 0; v < 256; v++) begin
            v8 = 8'(v);
            if (fault_add(mode, v8[3:0], v8[7:4]) != ({1'b0, v8[3:0]} + {1'b0, v8[7:4]})) begin
                errs++;
                if (!e.ffv) begin
                    e.ffv   = 1'b1;
                    e.ffvec = v8;
                end
            end
        end
        if (errs > (1 << errw) - 1) errs = (1 << errw) - 1;
        e.err    = 8'(errs);
        e.pass   = (errs == 0);
        e.cycles = 256 * (2 + settle);
        return e;
    endfunction

    task automatic run_sweep(input int i, input int settle, input int errw, input int mode,
                             input int p1, input int p2, input string tag);
        int   cycles;
        exp_t e;
        mode_v[i] = mode;
        exp_q.push_back(model_sweep(settle, errw, mode));
        @(negedge clk);
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
        cycles = 0;
        while (busy_v[i] && cycles < 2000) begin
            cycles++;
            if (cycles == 1) begin
                check({tag, " done cleared"}, 32'(done_v[i]), 0);
                check({tag, " err cleared"}, 32'(err_v[i]), 0);
            end
            start_v[i] = (cycles == p1) || (cycles == p2);
            @(negedge clk);
        end
        start_v[i] = 1'b0;
        e = exp_q.pop_front();
        check({tag, " busy cycles"}, 32'(cycles), 32'(e.cycles));
        check({tag, " done"}, 32'(done_v[i]), 1);
        check({tag, " pass"}, 32'(pass_v[i]), 32'(e.pass));
        check({tag, " err_count"}, 32'(err_v[i]), 32'(e.err));
        check({tag, " ff_valid"}, 32'(ffv_v[i]), 32'(e.ffv));
        check({tag, " ff_vec"}, 32'(ffvec_v[i]), 32'(e.ffvec));
        check({tag, " last dut_a"}, 32'(a_v[i]), 15);
        check({tag, " last dut_b"}, 32'(b_v[i]), 15);
    endtask

    initial begin
        int cycles;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle(0, "reset i0");
        check_idle(1, "reset i1");
        check_idle(2, "reset i2");

        run_sweep(0, 1, 8, 0, 0, 0, "ideal");

        run_sweep(0, 1, 8, 1, 0, 0, "sum0 stuck");
        check("sum0 stuck known err", 32'(err_v[0]), 128);
        check("sum0 stuck known vec", 32'(ffvec_v[0]), 32'h01);

        run_sweep(0, 1, 8, 2, 0, 0, "cout stuck");
        check("cout stuck known err", 32'(err_v[0]), 120);
        check("cout stuck known vec", 32'(ffvec_v[0]), 32'h1F);

        run_sweep(1, 1, 4, 3, 0, 0, "saturate");
        check("saturate known err", 32'(err_v[1]), 15);

        // Reset in the middle of a faulty sweep so err_count is non-zero.
        mode_v[0] = 1;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        cycles = 0;
        while (busy_v[0] && cycles < 99) begin
            cycles++;
            @(negedge clk);
        end
        check("mid-sweep still busy", 32'(busy_v[0]), 1);
        check("mid-sweep errors seen", 32'(err_v[0] != 0), 1);
        rst = 1'b1;
        start_v[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_v[0] = 1'b0;
        check_idle(0, "mid reset");
        @(negedge clk);
        check("idle after reset busy", 32'(busy_v[0]), 0);

        run_sweep(0, 1, 8, 0, 10, 300, "ignore start");

        run_sweep(2, 0, 8, 0, 0, 0, "settle0 first");
        run_sweep(2, 0, 8, 0, 0, 0, "settle0 second");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
